// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned MASTER0 = 0;
  localparam int unsigned MASTER1 = 1;

  // Watchdog counter width; at least one bit so a disabled watchdog still elaborates.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Strobe watchdog: pulses expire when a strobe has waited TIMEOUT cycles unanswered.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic stb,
  input  logic ack,
  input  logic err,
  input  logic clear,
  output logic expire
);

  localparam int unsigned     CW     = cnt_width(TIMEOUT);
  localparam bit              ENABLE = (TIMEOUT != 0);
  localparam logic [CW-1:0]   LIMIT  = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Expiry fires in the cycle the count sits at its limit; a slave response that cycle wins.
  always_comb begin
    expire = ENABLE & stb & ~ack & ~err & (count == LIMIT);
  end

  // Count unanswered strobe cycles; any response, idle strobe, state change or expiry restarts it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (!ENABLE || clear || expire || !stb || ack || err) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter: round-robin on ties, one idle cycle between grants,
// combinational bus mux from the owning master, and a strobe watchdog.
module wb_arb2
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [1:0]        m_cyc_i,
  input  logic [1:0]        m_stb_i,
  input  logic [1:0]        m_we_i,
  input  logic [2*DW/8-1:0] m_sel_i,
  input  logic [2*AW-1:0]   m_adr_i,
  input  logic [2*DW-1:0]   m_dat_i,
  output logic [DW-1:0]     m_dat_o,
  output logic [1:0]        m_ack_o,
  output logic [1:0]        m_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [1:0]        grant_o
);

  localparam int unsigned SW = DW / 8;

  arb_state_e        state;
  logic              last;
  logic              active;
  logic              owner;
  logic              own_cyc;
  logic              own_stb;
  logic              own_we;
  logic [SW-1:0]     own_sel;
  logic [AW-1:0]     own_adr;
  logic [DW-1:0]     own_dat;
  logic              leave;
  logic              expire;

  // Select the owning master's request signals.
  always_comb begin
    active  = (state != ST_IDLE);
    owner   = (state == ST_OWN1);
    own_cyc = owner ? m_cyc_i[MASTER1] : m_cyc_i[MASTER0];
    own_stb = owner ? m_stb_i[MASTER1] : m_stb_i[MASTER0];
    own_we  = owner ? m_we_i[MASTER1]  : m_we_i[MASTER0];
    own_sel = owner ? m_sel_i[SW +: SW] : m_sel_i[0 +: SW];
    own_adr = owner ? m_adr_i[AW +: AW] : m_adr_i[0 +: AW];
    own_dat = owner ? m_dat_i[DW +: DW] : m_dat_i[0 +: DW];
    leave   = active & ~own_cyc;
  end

  wb_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .stb     (active & own_stb),
    .ack     (s_ack_i),
    .err     (s_err_i),
    .clear   (leave),
    .expire  (expire)
  );

  // Drive the slave from the owner and route responses back; everything quiet when idle.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = s_dat_i;
    if (active) begin
      s_cyc_o        = own_cyc;
      s_stb_o        = own_stb & ~expire;
      s_we_o         = own_we;
      s_sel_o        = own_sel;
      s_adr_o        = own_adr;
      s_dat_o        = own_dat;
      m_ack_o[owner] = s_ack_i;
      m_err_o[owner] = s_err_i | expire;
    end
  end

  // Ownership FSM with registered grant; ties go to the master not granted last.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      grant_o <= '0;
      last    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_cyc_i == 2'b01 || (m_cyc_i == 2'b11 && last)) begin
            state   <= ST_OWN0;
            grant_o <= 2'b01;
          end else if (m_cyc_i[MASTER1]) begin
            state   <= ST_OWN1;
            grant_o <= 2'b10;
          end
        end
        ST_OWN0: begin
          if (!m_cyc_i[MASTER0]) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            last    <= 1'b0;
          end
        end
        ST_OWN1: begin
          if (!m_cyc_i[MASTER1]) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            last    <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: directed scenarios plus randomized traffic
// compared every cycle against a behavioural ownership model.
module tb_wb_arb2;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        m_cyc, m_stb, m_we;
  logic [2*SW-1:0]   m_sel;
  logic [2*AW-1:0]   m_adr;
  logic [2*DW-1:0]   m_dat;
  logic [DW-1:0]     m_dat_o;
  logic [1:0]        m_ack_o, m_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [SW-1:0]     s_sel_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW-1:0]     s_dat;
  logic              s_ack, s_err;
  logic [1:0]        grant_o;

  int total = 0;
  int bad   = 0;
  bit running = 1'b0;

  // Model state: current owner (-1 none), last owner, unanswered-strobe cycle count.
  int m_owner;
  int m_last;
  int m_cnt;

  always #5 clk = ~clk;

  wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat),
    .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_expire();
    if (m_owner < 0) return 1'b0;
    return m_stb[m_owner] && !s_ack && !s_err && (m_cnt == int'(TO) - 1);
  endfunction

  // Reference ownership model, advanced on each clock edge from the applied inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 1;
      m_cnt   <= 0;
    end else if (m_owner < 0) begin
      m_cnt <= 0;
      if (m_cyc == 2'b11)  m_owner <= 1 - m_last;
      else if (m_cyc[0])   m_owner <= 0;
      else if (m_cyc[1])   m_owner <= 1;
    end else if (!m_cyc[m_owner]) begin
      m_last  <= m_owner;
      m_owner <= -1;
      m_cnt   <= 0;
    end else if (m_stb[m_owner] && !s_ack && !s_err && !model_expire()) begin
      m_cnt <= m_cnt + 1;
    end else begin
      m_cnt <= 0;
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (running) begin
      logic        e_cyc, e_stb, e_we, ex;
      logic [SW-1:0] e_sel;
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_dat;
      logic [1:0]  e_ack, e_err, e_gnt;
      int n;
      e_cyc = 0; e_stb = 0; e_we = 0; e_sel = '0; e_adr = '0; e_dat = '0;
      e_ack = '0; e_err = '0; e_gnt = '0;
      n = m_owner;
      if (rst_n && n >= 0) begin
        ex       = model_expire();
        e_gnt[n] = 1'b1;
        e_cyc    = m_cyc[n];
        e_stb    = m_stb[n] && !ex;
        e_we     = m_we[n];
        e_sel    = m_sel[n*SW +: SW];
        e_adr    = m_adr[n*AW +: AW];
        e_dat    = m_dat[n*DW +: DW];
        e_ack[n] = s_ack;
        e_err[n] = s_err | ex;
      end
      chk("grant", 64'(grant_o), 64'(e_gnt));
      chk("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
      chk("s_stb", 64'(s_stb_o), 64'(e_stb));
      chk("s_we",  64'(s_we_o),  64'(e_we));
      chk("s_sel", 64'(s_sel_o), 64'(e_sel));
      chk("s_adr", 64'(s_adr_o), 64'(e_adr));
      chk("s_dat", 64'(s_dat_o), 64'(e_dat));
      chk("m_ack", 64'(m_ack_o), 64'(e_ack));
      chk("m_err", 64'(m_err_o), 64'(e_err));
      chk("m_dat", 64'(m_dat_o), 64'(s_dat));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 0; s_err = 0;
  endtask

  // Watchdog scenario: strobe held unanswered; optionally the slave acks in the expiry cycle.
  task automatic wd_run(input bit ack_win);
    m_cyc = 2'b01; m_stb = 2'b01; s_ack = 0; s_err = 0;
    at_neg();
    next();
    for (int i = 1; i <= int'(TO); i++) begin
      if (ack_win && i == int'(TO)) s_ack = 1;
      at_neg();
      chk("wd_err", 64'(m_err_o), (i == int'(TO) && !ack_win) ? 64'h1 : 64'h0);
      chk("wd_stb", 64'(s_stb_o), (i == int'(TO) && !ack_win) ? 64'h0 : 64'h1);
      if (ack_win && i == int'(TO)) chk("wd_ackwin", 64'(m_ack_o), 64'h1);
      next();
      s_ack = 0;
    end
    at_neg();
    chk("wd_after", 64'(m_err_o), 64'h0);
    idle_inputs();
    next();
    next();
  endtask

  initial begin
    int ack_pct;
    rst_n = 0; idle_inputs();
    m_sel = '0; m_adr = '0; m_dat = '0; s_dat = 32'h1234_5678;
    running = 1'b1;
    repeat (3) next();
    at_neg();
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_scyc", 64'(s_cyc_o), 64'h0);
    next();
    rst_n = 1;

    // Tie from reset goes to master 0, then strict alternation.
    next(); m_cyc = 2'b11;
    at_neg(); chk("tie_idle", 64'(grant_o), 64'h0);
    next(); m_stb = 2'b11; m_adr = {32'h0000_0200, 32'h0000_0104}; s_ack = 1;
    at_neg(); chk("tie_g0", 64'(grant_o), 64'h1);
    chk("m1_blocked_adr", 64'(s_adr_o), 64'h104);
    chk("own0_ack", 64'(m_ack_o), 64'h1);
    next(); m_cyc = 2'b10; m_stb = 2'b10; s_ack = 0;
    at_neg(); chk("drop_g0", 64'(grant_o), 64'h1);
    chk("m1_noack", 64'(m_ack_o), 64'h0);
    next(); s_ack = 1;
    at_neg(); chk("gap_idle", 64'(grant_o), 64'h0);
    chk("stale_ack", 64'(m_ack_o), 64'h0);
    next();
    at_neg(); chk("tie_g1", 64'(grant_o), 64'h2);
    chk("own1_adr", 64'(s_adr_o), 64'h200);
    chk("own1_ack", 64'(m_ack_o), 64'h2);
    next(); m_cyc = 2'b01; s_ack = 0;
    next(); m_cyc = 2'b11;
    at_neg(); chk("gap_idle2", 64'(grant_o), 64'h0);
    next();
    at_neg(); chk("alt_g0", 64'(grant_o), 64'h1);
    next(); idle_inputs();
    next(); next();

    // Single write from master 0.
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_sel = 8'h0F;
    m_adr = {32'h0, 32'h0000_0100}; m_dat = {32'h0, 32'hDEAD_BEEF};
    at_neg(); chk("wr_idle", 64'(grant_o), 64'h0);
    next(); s_ack = 1;
    at_neg();
    chk("wr_grant", 64'(grant_o), 64'h1);
    chk("wr_adr", 64'(s_adr_o), 64'h100);
    chk("wr_dat", 64'(s_dat_o), 64'hDEAD_BEEF);
    chk("wr_we", 64'(s_we_o), 64'h1);
    chk("wr_ack", 64'(m_ack_o), 64'h1);
    next(); idle_inputs();
    next(); next();

    wd_run(1'b0);
    wd_run(1'b1);

    // Reset in the middle of a master-1 burst.
    m_cyc = 2'b10; m_stb = 2'b10; m_adr = {32'h0000_0300, 32'h0};
    at_neg();
    next(); s_ack = 1;
    at_neg(); chk("pre_rst_g1", 64'(grant_o), 64'h2);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_grant", 64'(grant_o), 64'h0);
    chk("rst_mid_scyc", 64'(s_cyc_o), 64'h0);
    chk("rst_mid_sstb", 64'(s_stb_o), 64'h0);
    chk("rst_mid_sadr", 64'(s_adr_o), 64'h0);
    chk("rst_mid_ack", 64'(m_ack_o), 64'h0);
    next(); next();
    rst_n = 1; m_cyc = 2'b11; m_stb = 2'b11;
    at_neg();
    chk("post_rst_stale", 64'(m_ack_o), 64'h0);
    chk("post_rst_idle", 64'(grant_o), 64'h0);
    next();
    at_neg(); chk("post_rst_g0", 64'(grant_o), 64'h1);
    next(); idle_inputs();
    next();

    // Randomized traffic with varying slave responsiveness.
    ack_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      next();
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 0;
          1: ack_pct = 8;
          default: ack_pct = 50;
        endcase
      end
      rst_n = ($urandom_range(0, 499) != 0);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 7) == 0) m_cyc[m] = ~m_cyc[m];
        m_stb[m] = ($urandom_range(0, 3) != 0);
        m_we[m]  = 1'($urandom);
      end
      m_sel = 8'($urandom);
      m_adr = {$urandom, $urandom};
      m_dat = {$urandom, $urandom};
      s_dat = $urandom;
      s_ack = ($urandom_range(0, 99) < ack_pct);
      s_err = ($urandom_range(0, 29) == 0);
    end
    next();
    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
